rr_arb_4x_nbit: RTL and testbench
=================================

RR_ARB_4X_NBIT -- requirements
Module: rr_arb_4x_nbit

Interface
REQ-001 The block SHALL have parameter BUS_WIDTH, default 8, giving the data width of every data port.
REQ-002 The block SHALL have port clk, input, 1 bit; the single clock, and all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit; reset that is synchronous and active-high.
REQ-004 The block SHALL have ports a, b, c, d, input, BUS_WIDTH each; the data for channels 0, 1, 2 and 3.
REQ-005 The block SHALL have port valid_i, input, 4 bits; bit i high means channel i holds a word.
REQ-006 The block SHALL have port ready_o, output, 4 bits; bit i high means channel i's word is accepted this cycle.
REQ-007 The block SHALL have port y, output, BUS_WIDTH; the registered granted word.
REQ-008 The block SHALL have port valid_o, output, 1 bit; y holds a word.
REQ-009 The block SHALL have port ready_i, input, 1 bit; the consumer accepts y this cycle.
REQ-010 The block SHALL have port sel, output, 2 bits; the registered index of the channel held in y, used to drive the downstream 4:1 mux select.

Function
REQ-011 The block SHALL implement states IDLE (valid_o=0) and HOLD (valid_o=1).
REQ-012 The block SHALL define load = (state==IDLE) or (valid_o and ready_i).
REQ-013 When load=1 and valid_i is non-zero, the block SHALL pick as winner the first set bit of valid_i, searching ptr, ptr+1, ptr+2, ptr+3 modulo 4.
REQ-014 ready_o SHALL be combinational and one-hot at the winner only when load=1 and valid_i is non-zero, and SHALL be 0 otherwise.
REQ-015 A channel with valid_i=0 SHALL never be granted.
REQ-016 On a load with a winner, the block SHALL at the next edge set y to the winner's data, sel to the winner index, valid_o to 1, state to HOLD, and ptr to (winner+1) mod 4, wrapping 3->0.
REQ-017 On a load with valid_i=0, the block SHALL at the next edge set valid_o to 0 and state to IDLE, and SHALL hold y and sel.
REQ-018 In HOLD with ready_i=0, the block SHALL hold y, sel and valid_o stable and keep ready_o at 0.
REQ-019 A simultaneous accept (ready_i=1) and new request SHALL reload in the same cycle, giving one word per cycle with no bubble.
REQ-020 Latency from a channel's ready_o pulse to valid_o with that data SHALL be 1 cycle.
REQ-021 ready_i asserted while valid_o=0 SHALL have no effect.
REQ-022 Changes on valid_i or data without a ready_o pulse SHALL NOT alter y.

Reset
REQ-023 While rst=1 at a clock edge, the block SHALL set y=0, sel=0, valid_o=0, ptr=0, state=IDLE and burst count=0.
REQ-024 While rst=1, ready_o SHALL be 0.
REQ-025 Reset during HOLD SHALL drop the held word, with no accept generated for it.

Configuration
REQ-026 The block SHALL support macro RR_ARB_BURST_EN.
REQ-027 With RR_ARB_BURST_EN defined, a winner g that has valid_i[g]=1 at the next load SHALL win again, up to 4 consecutive grants.
REQ-028 With RR_ARB_BURST_EN defined, a 2-bit burst counter SHALL count those consecutive grants.
REQ-029 With RR_ARB_BURST_EN defined, after the 4th consecutive grant, or when valid_i[g]=0 at a load, the block SHALL apply REQ-013 with ptr=(g+1) mod 4 and clear the counter.
REQ-030 Without RR_ARB_BURST_EN, the block SHALL use strict rotation per REQ-013/REQ-016 and SHALL contain no counter logic.

Verification
REQ-031 Reset test: hold rst=1 with valid_i=4'hF -> y=0, sel=0, valid_o=0 and ready_o=0 on every cycle.
REQ-032 Single request: set valid_i=4'b0100 with c=8'hA5 and ready_i=1 -> ready_o=4'b0100 in cycle 0; y=8'hA5, sel=2 and valid_o=1 in cycle 1.
REQ-033 Rotation: hold valid_i=4'hF and ready_i=1, burst off -> sel sequence 0,1,2,3,0 on consecutive cycles with no bubble.
REQ-034 Backpressure: hold ready_i=0 for 5 cycles in HOLD -> y and sel stable and ready_o=0; raising ready_i then loads the next winner in the same cycle.
REQ-035 Burst: hold valid_i=4'hF and ready_i=1 with RR_ARB_BURST_EN defined -> sel sequence 0,0,0,0,1,1,1,1,2.
REQ-036 Mid-reset: assert rst in HOLD with ready_i=0 -> valid_o=0 the next cycle, and the next grant starts from channel 0.

Source files
------------

// File: rtl/rr_arb_4x_nbit.sv
// rr_arb_4x_nbit: 4-channel round-robin arbiter with registered granted word and sel.
// Define RR_ARB_BURST_EN to let a winner keep the grant for up to 4 consecutive loads.
module rr_arb_4x_nbit #(
   parameter int BUS_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BUS_WIDTH-1:0] a,
   input  logic [BUS_WIDTH-1:0] b,
   input  logic [BUS_WIDTH-1:0] c,
   input  logic [BUS_WIDTH-1:0] d,
   input  logic [3:0]           valid_i,
   output logic [3:0]           ready_o,
   output logic [BUS_WIDTH-1:0] y,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [1:0]           sel
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] HOLD = 1'b1;
   logic [0:0] state;
   logic [1:0] ptr, off, win;
   logic [3:0] rot;
   logic load, any;
   logic [BUS_WIDTH-1:0] wd;
   // rot[k] is the request k positions after ptr, so the first set bit is the rotating winner
   always_comb begin
      rot = '0;
      for (int k = 0; k < 4; k++) rot[k] = valid_i[ptr + 2'(k)];
   end
   assign off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
   assign any = |valid_i;
   assign valid_o = state == HOLD;
   assign load = state == IDLE || (valid_o && ready_i);
`ifdef RR_ARB_BURST_EN
   logic [1:0] cnt;
   logic keep;
   assign keep = state == HOLD && valid_i[sel] && cnt != 2'd3;
   assign win = keep ? sel : ptr + off;
`else
   assign win = ptr + off;
`endif
   assign wd = win == 2'd0 ? a : win == 2'd1 ? b : win == 2'd2 ? c : d;
   assign ready_o = (!rst && load && any) ? 4'b0001 << win : 4'b0000;
   always_ff @(posedge clk) begin
      if (rst) begin
         y <= '0;
         sel <= '0;
         ptr <= '0;
         state <= IDLE;
`ifdef RR_ARB_BURST_EN
         cnt <= '0;
`endif
      end else if (load) begin
         if (any) begin
            y <= wd;
            sel <= win;
            ptr <= win + 2'd1;
            state <= HOLD;
`ifdef RR_ARB_BURST_EN
            cnt <= keep ? cnt + 2'd1 : 2'd0;
`endif
         end else begin
            state <= IDLE;
`ifdef RR_ARB_BURST_EN
            cnt <= '0;
`endif
         end
      end
   end
endmodule

// File: tb/tb_rr_arb_4x_nbit.sv
// tb_rr_arb_4x_nbit: directed and randomized checks of rr_arb_4x_nbit against a behavioural model.
module tb_rr_arb_4x_nbit;
   localparam int W = 8;
   logic clk = 1'b0;
   logic rst;
   logic [W-1:0] a, b, c, d, y;
   logic [3:0] valid_i, ready_o;
   logic valid_o, ready_i;
   logic [1:0] sel;
   int checks = 0;
   int errors = 0;
   int m_ptr, m_sel, m_run, m_win;
   logic m_vo;
   logic [W-1:0] m_y, hold_y;
   logic [3:0] exp_ready;
   bit m_keep;
   int seq[$];
   int hold_sel;

   rr_arb_4x_nbit #(.BUS_WIDTH(W)) dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
      .valid_i(valid_i), .ready_o(ready_o), .y(y), .valid_o(valid_o),
      .ready_i(ready_i), .sel(sel)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] data_of(input int i);
      return i == 0 ? a : i == 1 ? b : i == 2 ? c : d;
   endfunction

   // Search ptr, ptr+1, ... modulo 4 for the first requesting channel.
   function automatic int pick(input logic [3:0] v, input int p);
      for (int i = 0; i < 4; i++) if (v[(p + i) % 4]) return (p + i) % 4;
      return -1;
   endfunction

   task automatic step();
      bit load;
      @(negedge clk);
      load = !m_vo || ready_i;
      m_keep = 0;
`ifdef RR_ARB_BURST_EN
      m_keep = m_vo && valid_i[m_sel] && m_run < 4;
`endif
      m_win = m_keep ? m_sel : pick(valid_i, m_ptr);
      exp_ready = (!rst && load && m_win >= 0) ? 4'(1 << m_win) : 4'b0000;
      check("ready_o", 32'(ready_o), 32'(exp_ready));
      @(posedge clk);
      if (rst) begin
         m_y = '0; m_sel = 0; m_vo = 0; m_ptr = 0; m_run = 0;
      end else if (load) begin
         if (m_win >= 0) begin
            m_y = data_of(m_win);
            m_run = m_keep ? m_run + 1 : 1;
            m_sel = m_win; m_vo = 1; m_ptr = (m_win + 1) % 4;
         end else begin
            m_vo = 0; m_run = 0;
         end
      end
      #1;
      check("y", 32'(y), 32'(m_y));
      check("sel", 32'(sel), 32'(m_sel));
      check("valid_o", 32'(valid_o), 32'(m_vo));
   endtask

   task automatic rnd_data();
      a = W'($urandom); b = W'($urandom); c = W'($urandom); d = W'($urandom);
   endtask

   initial begin
      m_y = '0; m_sel = 0; m_vo = 0; m_ptr = 0; m_run = 0;
      rst = 1; valid_i = 4'hF; ready_i = 1; rnd_data();
      for (int i = 0; i < 3; i++) begin
         step();
         check("reset_y", 32'(y), 0);
         check("reset_valid_o", 32'(valid_o), 0);
      end
      rst = 0; valid_i = 4'b0100; c = 8'hA5;
      @(negedge clk);
      check("single_ready", 32'(ready_o), 32'h4);
      step();
      check("single_y", 32'(y), 32'hA5);
      check("single_sel", 32'(sel), 2);
      check("single_valid", 32'(valid_o), 1);
      rst = 1; step(); rst = 0;
`ifdef RR_ARB_BURST_EN
      seq = '{0, 0, 0, 0, 1, 1, 1, 1, 2};
`else
      seq = '{0, 1, 2, 3, 0};
`endif
      valid_i = 4'hF; ready_i = 1;
      foreach (seq[i]) begin
         rnd_data();
         step();
         check("rot_sel", 32'(sel), 32'(seq[i]));
         check("rot_valid", 32'(valid_o), 1);
      end
      ready_i = 0;
      hold_y = y; hold_sel = int'(sel);
      for (int i = 0; i < 5; i++) begin
         rnd_data(); valid_i = 4'($urandom_range(1, 15));
         step();
         check("bp_y", 32'(y), 32'(hold_y));
         check("bp_sel", 32'(sel), 32'(hold_sel));
      end
      ready_i = 1; valid_i = 4'hF; step();
      check("bp_reload_valid", 32'(valid_o), 1);
      ready_i = 0; step();
      rst = 1; step();
      check("midrst_valid", 32'(valid_o), 0);
      rst = 0; ready_i = 1; valid_i = 4'hF; step();
      check("midrst_sel", 32'(sel), 0);
      valid_i = 4'b0000; step();
      check("empty_valid", 32'(valid_o), 0);
      for (int i = 0; i < 400; i++) begin
         rnd_data();
         valid_i = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom);
         ready_i = $urandom_range(0, 3) != 0;
         rst = $urandom_range(0, 60) == 0;
         step();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
